// File: rtl/gpu_tile_writer.sv
// gpu_tile_writer
//
// Walks a MY_ROWS x MY_COLS tile of pixels, placed at (start_row, start_col)
// inside a TOTAL_ROWS x TOTAL_COLS frame, and writes each pixel that lands
// inside the frame to memory through an Avalon-MM write-only master. Pixels
// falling outside the frame are skipped. A pixel of PIXEL_BYTES bytes goes out
// as BEATS = PIXEL_BYTES/BUS_BYTES consecutive bus beats, least significant
// bytes first, at consecutive addresses.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   start_row, start_col    tile origin in the frame
//   pixel_buffer            frame base byte address
//   start                   begin a writeout (ignored while busy)
//   abort                   cancel the writeout in progress
//   clear_interrupt         drop done_rendering and return to idle
//   sel_row, sel_col        tile-local coordinate of the pixel being fetched
//   pixel                   pixel value for (sel_row, sel_col)
//   m1_*                    Avalon-MM write master
//   busy                    writeout in progress
//   done_rendering          tile finished, waiting for clear or restart
//
// Handshake: a beat is offered while m1_write=1 and is accepted on the rising
// edge where m1_waitrequest=0; while m1_waitrequest=1 the address, data and
// write strobe stay frozen.
module gpu_tile_writer #(
  parameter int MY_ROWS    = 2,
  parameter int MY_COLS    = 2,
  parameter int TOTAL_ROWS = 4,
  parameter int TOTAL_COLS = 4,
  parameter int PIXEL_BITS = 16,
  parameter int BUS_BYTES  = 1,
  localparam int ROW_BITS  = $clog2(TOTAL_ROWS),
  localparam int COL_BITS  = $clog2(TOTAL_COLS),
  localparam int SROW_BITS = (MY_ROWS > 1) ? $clog2(MY_ROWS) : 1,
  localparam int SCOL_BITS = (MY_COLS > 1) ? $clog2(MY_COLS) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ROW_BITS-1:0]    start_row,
  input  logic [COL_BITS-1:0]    start_col,
  input  logic [31:0]            pixel_buffer,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   clear_interrupt,
  output logic [SROW_BITS-1:0]   sel_row,
  output logic [SCOL_BITS-1:0]   sel_col,
  input  logic [PIXEL_BITS-1:0]  pixel,
  output logic [31:0]            m1_address,
  output logic [BUS_BYTES*8-1:0] m1_writedata,
  output logic [BUS_BYTES-1:0]   m1_byteenable,
  output logic                   m1_write,
  input  logic                   m1_waitrequest,
  output logic                   busy,
  output logic                   done_rendering
);

  localparam int PIXEL_BYTES = PIXEL_BITS / 8;
  localparam int BEATS       = PIXEL_BYTES / BUS_BYTES;
  localparam int BUS_BITS    = BUS_BYTES * 8;
  localparam int BEAT_BITS   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [SROW_BITS-1:0] ROW_LAST  = SROW_BITS'(MY_ROWS - 1);
  localparam logic [SCOL_BITS-1:0] COL_LAST  = SCOL_BITS'(MY_COLS - 1);
  localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_WRITE     = 3'd2,
    S_NEXT      = 3'd3,
    S_INTERRUPT = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SROW_BITS-1:0]   r_q, r_d;
  logic [SCOL_BITS-1:0]   c_q, c_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  logic [31:0]            addr_q, addr_d;
  logic [PIXEL_BITS-1:0]  hold_q, hold_d;

  // Frame coordinate of the current tile pixel, kept in 32 bits so the
  // clipping compare cannot wrap for origins near the frame edge.
  logic [31:0] gr, gc, pix_offset;
  logic        clipped;
  logic        last_pixel;
  logic [PIXEL_BITS-1:0] hold_shifted;

  assign gr         = 32'(start_row) + 32'(r_q);
  assign gc         = 32'(start_col) + 32'(c_q);
  assign clipped    = (gr >= 32'(TOTAL_ROWS)) || (gc >= 32'(TOTAL_COLS));
  assign pix_offset = (gr * 32'(TOTAL_COLS) + gc) * 32'(PIXEL_BYTES);
  assign last_pixel = (r_q == ROW_LAST) && (c_q == COL_LAST);

  // Beat n carries bytes [n*BUS_BYTES +: BUS_BYTES] of the held pixel.
  assign hold_shifted = hold_q >> (BUS_BITS * int'(beat_q));

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          r_d     = '0;
          c_d     = '0;
        end
      end
      S_ADDR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (clipped) begin
          state_d = S_NEXT;
        end else begin
          addr_d  = pixel_buffer + pix_offset;
          hold_d  = pixel;
          beat_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Nothing moves until the slave takes the current beat; an abort
        // lets that beat finish and drops the rest.
        if (!m1_waitrequest) begin
          if (abort) begin
            state_d = S_IDLE;
          end else if (beat_q == BEAT_LAST) begin
            state_d = S_NEXT;
          end else begin
            addr_d = addr_q + 32'(BUS_BYTES);
            beat_d = beat_q + BEAT_BITS'(1);
          end
        end
      end
      S_NEXT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (c_q == COL_LAST) begin
            c_d = '0;
            r_d = r_q + SROW_BITS'(1);
          end else begin
            c_d = c_q + SCOL_BITS'(1);
          end
          state_d = last_pixel ? S_INTERRUPT : S_ADDR;
        end
      end
      S_INTERRUPT: begin
        if (clear_interrupt) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_ADDR;
          r_d     = '0;
          c_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  // Bus strobes decode straight from the state register so an asynchronous
  // reset clears them in the same cycle.
  assign m1_write       = (state_q == S_WRITE);
  assign m1_byteenable  = {BUS_BYTES{m1_write}};
  assign m1_writedata   = m1_write ? hold_shifted[BUS_BITS-1:0] : '0;
  assign m1_address     = addr_q;
  assign sel_row        = r_q;
  assign sel_col        = c_q;
  assign busy           = (state_q == S_ADDR) || (state_q == S_WRITE) ||
                          (state_q == S_NEXT);
  assign done_rendering = (state_q == S_INTERRUPT);

endmodule

// File: tb/tb_gpu_tile_writer.sv
// Bench for gpu_tile_writer: two instances on a shared clock and shared
// control inputs, one with an 8-bit bus (two beats per pixel) and one with a
// 16-bit bus (one beat per pixel). Accepted beats from each are logged and
// compared with a queue built from the frame/tile addressing rules.
module tb_gpu_tile_writer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  start_row = '0;
  logic [1:0]  start_col = '0;
  logic [31:0] pixel_buffer = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        clear_interrupt = 1'b0;
  logic        m1_waitrequest = 1'b0;

  logic [0:0]  sel_row, sel_col;
  logic [15:0] pixel;
  logic [31:0] m1_address;
  logic [7:0]  m1_writedata;
  logic [0:0]  m1_byteenable;
  logic        m1_write, busy, done_rendering;

  logic [0:0]  sel_row2, sel_col2;
  logic [15:0] pixel2;
  logic [31:0] m1_address2;
  logic [15:0] m1_writedata2;
  logic [1:0]  m1_byteenable2;
  logic        m1_write2, busy2, done2;

  logic [15:0] tile_pix [4];

  assign pixel  = tile_pix[{sel_row, sel_col}];
  assign pixel2 = tile_pix[{sel_row2, sel_col2}];

  gpu_tile_writer dut (
    .clock(clock), .reset_n(reset_n), .start_row(start_row), .start_col(start_col),
    .pixel_buffer(pixel_buffer), .start(start), .abort(abort),
    .clear_interrupt(clear_interrupt), .sel_row(sel_row), .sel_col(sel_col),
    .pixel(pixel), .m1_address(m1_address), .m1_writedata(m1_writedata),
    .m1_byteenable(m1_byteenable), .m1_write(m1_write),
    .m1_waitrequest(m1_waitrequest), .busy(busy), .done_rendering(done_rendering)
  );

  gpu_tile_writer #(.BUS_BYTES(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start_row(start_row), .start_col(start_col),
    .pixel_buffer(pixel_buffer), .start(start), .abort(abort),
    .clear_interrupt(clear_interrupt), .sel_row(sel_row2), .sel_col(sel_col2),
    .pixel(pixel2), .m1_address(m1_address2), .m1_writedata(m1_writedata2),
    .m1_byteenable(m1_byteenable2), .m1_write(m1_write2),
    .m1_waitrequest(m1_waitrequest), .busy(busy2), .done_rendering(done2)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  // Entry layout: {address[31:0], byteenable[3:0], data[15:0]}
  logic [51:0] exp_q[$];
  logic [51:0] obs_q[$];
  logic [51:0] obs2_q[$];
  int total = 0;
  int bad   = 0;

  always @(negedge clock) begin
    if (m1_write && !m1_waitrequest)
      obs_q.push_back({m1_address, 3'b000, m1_byteenable, 8'h00, m1_writedata});
    if (m1_write2 && !m1_waitrequest)
      obs2_q.push_back({m1_address2, 2'b00, m1_byteenable2, m1_writedata2});
  end

  // Reference model: visits the tile in row-major order, skips pixels outside
  // the 4x4 frame, and lists every beat with its address and data. Returns
  // the cycle count from ADDR entry to done for a run with no wait states.
  task automatic build_exp(input int sr, input int sc, input logic [31:0] base,
                           input int bb, output int exp_cyc);
    int beats;
    beats   = 2 / bb;
    exp_cyc = 0;
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        int gr, gc;
        gr = sr + r;
        gc = sc + c;
        if (gr < 4 && gc < 4) begin
          logic [31:0] a;
          a = base + 32'((gr * 4 + gc) * 2);
          for (int b = 0; b < beats; b++) begin
            logic [15:0] d;
            logic [3:0]  be;
            d  = tile_pix[r * 2 + c] >> (8 * b * bb);
            if (bb == 1) d = d & 16'h00ff;
            be = (bb == 1) ? 4'h1 : 4'h3;
            exp_q.push_back({a + 32'(b * bb), be, d});
          end
          exp_cyc += 2 + beats;
        end else begin
          exp_cyc += 2;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks begin and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drv_clear();
    clear_interrupt = 1'b1;
    step();
    clear_interrupt = 1'b0;
  endtask

  // Pulses start and waits for done on the 8-bit instance. wmode 0: no
  // waits, 1: random waits. cyc/cyc2: cycles from ADDR entry to done.
  task automatic run_tile(input int wmode, input bit rnd_start,
                          output int cyc, output int cyc2, output bit to);
    cyc  = -1;
    cyc2 = -1;
    to   = 1'b1;
    start = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      step();
      start = 1'b0;
      if (done2 && cyc2 < 0) cyc2 = i - 1;
      if (done_rendering) begin
        cyc = i - 1;
        to  = 1'b0;
        break;
      end
      m1_waitrequest = (wmode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (rnd_start && busy) start = 1'($urandom_range(0, 1));
    end
    m1_waitrequest = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    total++; if (m1_write !== 1'b0) begin bad++; $display("FAIL reset_write: got %0h want 0", m1_write); end
    total++; if (m1_address !== 32'h0) begin bad++; $display("FAIL reset_addr: got %0h want 0", m1_address); end
    total++; if ({m1_writedata, m1_byteenable} !== 9'h0) begin bad++; $display("FAIL reset_data_be: got %0h want 0", {m1_writedata, m1_byteenable}); end
    total++; if ({busy, done_rendering, sel_row, sel_col} !== 4'h0) begin bad++; $display("FAIL reset_status: got %0h want 0", {busy, done_rendering, sel_row, sel_col}); end
    step();
    reset_n = 1'b1;
    repeat (6) step();
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL post_reset_writes: got %0d want 0", obs_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %0h want 0", busy); end
  endtask

  task automatic test_basic();
    int ec, cyc, cyc2;
    bit to;
    start_row = 2'd0; start_col = 2'd2; pixel_buffer = 32'h1000;
    tile_pix[0] = 16'hA1B2; tile_pix[1] = 16'hC3D4; tile_pix[2] = 16'hE5F6; tile_pix[3] = 16'h0718;
    build_exp(0, 2, 32'h1000, 1, ec);
    obs_q.delete();
    run_tile(0, 1'b0, cyc, cyc2, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout: got timeout want done"); end
    total++; if (cyc != 16) begin bad++; $display("FAIL basic_latency: got %0d want 16", cyc); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (done_rendering !== 1'b1) begin bad++; $display("FAIL basic_done: got %0h want 1", done_rendering); end
    drv_clear();
    total++; if ({done_rendering, busy} !== 2'b00) begin bad++; $display("FAIL basic_clear: got %0h want 0", {done_rendering, busy}); end
  endtask

  task automatic test_clip();
    int ec, cyc, cyc2;
    bit to;
    start_row = 2'd3; start_col = 2'd3; pixel_buffer = 32'h1000;
    build_exp(3, 3, 32'h1000, 1, ec);
    obs_q.delete();
    run_tile(0, 1'b0, cyc, cyc2, to);
    total++; if (to) begin bad++; $display("FAIL clip_timeout: got timeout want done"); end
    total++; if (cyc != ec) begin bad++; $display("FAIL clip_latency: got %0d want %0d", cyc, ec); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL clip_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL clip_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    drv_clear();
  endtask

  task automatic test_wait();
    int ec, cyc, hold, nchk;
    start_row = 2'd0; start_col = 2'd2; pixel_buffer = 32'h1000;
    build_exp(0, 2, 32'h1000, 1, ec);
    obs_q.delete();
    cyc = -1; hold = 0; nchk = 0;
    start = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      step();
      start = 1'b0;
      if (done_rendering) begin cyc = i - 1; break; end
      if (hold >= 1 && nchk < 3) begin
        nchk++;
        total++; if (m1_write !== 1'b1) begin bad++; $display("FAIL wait_write: got %0h want 1", m1_write); end
        total++; if (m1_address !== exp_q[0][51:20]) begin bad++; $display("FAIL wait_addr: got %h want %h", m1_address, exp_q[0][51:20]); end
        total++; if (m1_writedata !== exp_q[0][7:0]) begin bad++; $display("FAIL wait_data: got %h want %h", m1_writedata, exp_q[0][7:0]); end
      end
      if (m1_write && hold < 3) begin
        m1_waitrequest = 1'b1;
        hold++;
      end else begin
        m1_waitrequest = 1'b0;
      end
    end
    m1_waitrequest = 1'b0;
    total++; if (nchk != 3) begin bad++; $display("FAIL wait_checks: got %0d want 3", nchk); end
    total++; if (cyc != ec + 3) begin bad++; $display("FAIL wait_latency: got %0d want %0d", cyc, ec + 3); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL wait_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL wait_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    drv_clear();
  endtask

  task automatic test_random();
    int ec, cyc, cyc2;
    bit to;
    for (int it = 0; it < 12; it++) begin
      start_row    = 2'($urandom_range(0, 3));
      start_col    = 2'($urandom_range(0, 3));
      pixel_buffer = $urandom;
      for (int k = 0; k < 4; k++) tile_pix[k] = 16'($urandom);
      build_exp(int'(start_row), int'(start_col), pixel_buffer, 1, ec);
      obs_q.delete();
      run_tile(1, 1'b1, cyc, cyc2, to);
      total++; if (to) begin bad++; $display("FAIL rand%0d_timeout: got timeout want done", it); end
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", it, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_beat%0d: got %h want %h", it, i, obs_q[i], exp_q[i]); end
      end
      drv_clear();
      total++; if (done_rendering !== 1'b0) begin bad++; $display("FAIL rand%0d_clear: got %0h want 0", it, done_rendering); end
    end
  endtask

  task automatic test_bus2();
    int ec, cyc, cyc2;
    bit to;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    start_row = 2'd0; start_col = 2'd2; pixel_buffer = 32'h1000;
    tile_pix[0] = 16'hA1B2; tile_pix[1] = 16'hC3D4; tile_pix[2] = 16'hE5F6; tile_pix[3] = 16'h0718;
    build_exp(0, 2, 32'h1000, 2, ec);
    obs2_q.delete();
    run_tile(0, 1'b0, cyc, cyc2, to);
    total++; if (cyc2 != 12) begin bad++; $display("FAIL bus2_latency: got %0d want 12", cyc2); end
    total++; if (obs2_q.size() != exp_q.size()) begin bad++; $display("FAIL bus2_count: got %0d want %0d", obs2_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs2_q.size(); i++) begin
      total++; if (obs2_q[i] !== exp_q[i]) begin bad++; $display("FAIL bus2_beat%0d: got %h want %h", i, obs2_q[i], exp_q[i]); end
    end
    drv_clear();
  endtask

  task automatic test_abort();
    int ec, phase, wc;
    start_row = 2'd0; start_col = 2'd2; pixel_buffer = 32'h1000;
    build_exp(0, 2, 32'h1000, 1, ec);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    obs_q.delete();
    phase = 0; wc = 0;
    start = 1'b1;
    for (int i = 1; i <= 100 && phase < 3; i++) begin
      step();
      start = 1'b0;
      case (phase)
        0: if (m1_write && m1_address == 32'h1006) begin
             m1_waitrequest = 1'b1; abort = 1'b1; phase = 1;
           end
        1: begin
             wc++;
             if (wc == 2) begin m1_waitrequest = 1'b0; phase = 2; end
           end
        default: begin abort = 1'b0; phase = 3; end
      endcase
    end
    abort = 1'b0;
    m1_waitrequest = 1'b0;
    total++; if (phase != 3) begin bad++; $display("FAIL abort_reach: got phase %0d want 3", phase); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle: got busy %0h want 0", busy); end
    for (int k = 0; k < 10; k++) begin
      step();
      total++; if ({m1_write, m1_writedata, m1_byteenable, busy, done_rendering} !== 12'h0) begin
        bad++; $display("FAIL abort_quiet%0d: got %h want 0", k, {m1_write, m1_writedata, m1_byteenable, busy, done_rendering}); end
    end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL abort_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort_addr();
    obs_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_addr_busy: got %0h want 1", busy); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_addr_idle: got %0h want 0", busy); end
    repeat (4) step();
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL abort_addr_writes: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    obs_q.delete();
    seen = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      start = 1'b0;
      if (m1_write) begin m1_waitrequest = 1'b1; seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL rst_mid_reach: got no write want write"); end
    step();
    #2 reset_n = 1'b0;
    #1;
    total++; if ({m1_write, m1_byteenable, m1_writedata} !== 10'h0) begin bad++; $display("FAIL rst_mid_bus: got %h want 0", {m1_write, m1_byteenable, m1_writedata}); end
    total++; if (m1_address !== 32'h0) begin bad++; $display("FAIL rst_mid_addr: got %h want 0", m1_address); end
    total++; if ({busy, done_rendering, sel_row, sel_col} !== 4'h0) begin bad++; $display("FAIL rst_mid_status: got %h want 0", {busy, done_rendering, sel_row, sel_col}); end
    step();
    reset_n = 1'b1;
    m1_waitrequest = 1'b0;
    repeat (5) step();
    total++; if (obs_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_after: got %0d writes busy %0h want 0 0", obs_q.size(), busy); end
  endtask

  task automatic test_interrupt();
    int ec, cyc, cyc2;
    bit to;
    start_row = 2'd0; start_col = 2'd2; pixel_buffer = 32'h2000;
    for (int k = 0; k < 4; k++) tile_pix[k] = 16'($urandom);
    build_exp(0, 2, 32'h2000, 1, ec);
    run_tile(0, 1'b0, cyc, cyc2, to);
    obs_q.delete();
    clear_interrupt = 1'b1;
    start = 1'b1;
    step();
    clear_interrupt = 1'b0;
    start = 1'b0;
    total++; if ({done_rendering, busy} !== 2'b00) begin bad++; $display("FAIL irq_clear_wins: got %0h want 0", {done_rendering, busy}); end
    repeat (3) step();
    total++; if (obs_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL irq_clear_idle: got %0d writes busy %0h want 0 0", obs_q.size(), busy); end
    run_tile(0, 1'b0, cyc, cyc2, to);
    for (int k = 0; k < 4; k++) tile_pix[k] = 16'($urandom);
    build_exp(0, 2, 32'h2000, 1, ec);
    obs_q.delete();
    run_tile(0, 1'b0, cyc, cyc2, to);
    total++; if (to || cyc != ec) begin bad++; $display("FAIL irq_restart_latency: got %0d want %0d", cyc, ec); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL irq_restart_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL irq_restart_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    drv_clear();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < 4; k++) tile_pix[k] = '0;
    test_reset();
    test_basic();
    test_clip();
    test_wait();
    test_random();
    test_bus2();
    test_abort();
    test_abort_addr();
    test_reset_mid_write();
    test_interrupt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
